tetromino_row_streamer: RTL and testbench

TETROMINO_ROW_STREAMER -- requirements
Module: tetromino_row_streamer

---
 rtl/template_pkg.sv | 7 +
 rtl/tetromino_row_streamer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tetromino_row_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/template_pkg.sv
// Cell template codes shared by the tetromino row streamer and its users.
package template_pkg;
  localparam logic [1:0] BLACK = 2'd0;
  localparam logic [1:0] WHITE = 2'd1;
  localparam logic [1:0] LIGHT = 2'd2;
  localparam logic [1:0] DARK  = 2'd3;
endpackage

// File: rtl/tetromino_row_streamer.sv
// Streams a rotated, cropped tetromino as WIN rows of occupancy plus per-cell templates.
// Optional horizontal mirroring is compiled in with the TETROMINO_MIRROR_EN macro.
module tetromino_row_streamer
  import template_pkg::*;
#(
  parameter int WIN = 4,
  parameter int TW  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             piece_id,
  input  logic [1:0]             rot_cmd,
  input  logic [2:0]             crop_left,
  input  logic [2:0]             crop_top,
  input  logic                   mirror,
  output logic                   row_valid,
  input  logic                   row_ready,
  output logic [WIN-1:0]         row_data,
  output logic [WIN*TW-1:0]      row_template,
  output logic [$clog2(WIN)-1:0] row_idx,
  output logic                   row_last,
  output logic [1:0]             rot_state,
  output logic                   bad_piece
);
  localparam int IW = $clog2(WIN);
  localparam logic [TW-1:0] C_BLACK = TW'(BLACK);
  localparam logic [TW-1:0] C_WHITE = TW'(WHITE);
  localparam logic [TW-1:0] C_LIGHT = TW'(LIGHT);
  localparam logic [TW-1:0] C_DARK  = TW'(DARK);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, STREAM = 2'd2} state_t;

  // Rows packed top-first: row 0 in [15:12], bit 3 of each nibble is the leftmost column.
  function automatic logic [15:0] shape_rows(input logic [2:0] p, input logic [1:0] r);
    logic [15:0] s;
    case (p)
      3'd0: s = 16'h0066;
      3'd1: s = r[0] ? 16'h2222 : 16'h0F00;
      3'd2: s = r[0] ? 16'h0132 : 16'h0063;
      3'd3: s = r[0] ? 16'h0231 : 16'h0036;
      3'd4: begin
        case (r)
          2'd0:    s = 16'h0072;
          2'd1:    s = 16'h0262;
          2'd2:    s = 16'h0270;
          default: s = 16'h0232;
        endcase
      end
      3'd5: begin
        case (r)
          2'd0:    s = 16'h0071;
          2'd1:    s = 16'h0226;
          2'd2:    s = 16'h0470;
          default: s = 16'h0322;
        endcase
      end
      3'd6: begin
        case (r)
          2'd0:    s = 16'h0074;
          2'd1:    s = 16'h0622;
          2'd2:    s = 16'h0170;
          default: s = 16'h0223;
        endcase
      end
      default: s = 16'h0000;
    endcase
    return s;
  endfunction

  // Orientation count minus one; counts are powers of two so masking is the modulo.
  function automatic logic [1:0] orient_mask(input logic [2:0] p);
    logic [1:0] m;
    case (p)
      3'd0:                m = 2'd0;
      3'd1, 3'd2, 3'd3:    m = 2'd1;
      3'd4, 3'd5, 3'd6:    m = 2'd3;
      default:             m = 2'd0;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] next_rot(input logic [1:0] r, input logic [1:0] cmd,
                                          input logic [1:0] m);
    logic [1:0] n;
    case (cmd)
      2'b01:   n = (r + 2'd1) & m;
      2'b10:   n = (r - 2'd1) & m;
      2'b11:   n = 2'd0;
      default: n = r;
    endcase
    return n;
  endfunction

  function automatic logic [TW-1:0] tcode_of(input logic [2:0] p);
    logic [TW-1:0] c;
    case (p)
      3'd0, 3'd1, 3'd4: c = C_WHITE;
      3'd2, 3'd6:       c = C_LIGHT;
      3'd3, 3'd5:       c = C_DARK;
      default:          c = C_BLACK;
    endcase
    return c;
  endfunction

  // Shape sits in the bottom four rows; crop_top selects a lower source row, crop_left shifts left.
  function automatic logic [WIN-1:0] build_row(input logic [15:0] shape, input logic [2:0] cl,
                                               input logic [2:0] ct, input int idx);
    int             src;
    logic [1:0]     k;
    logic [3:0]     nib;
    logic [WIN-1:0] r;
    src = idx + int'(ct);
    r   = '0;
    if (src >= WIN - 4 && src < WIN) begin
      k = 2'(src - (WIN - 4));
      case (k)
        2'd0:    nib = shape[15:12];
        2'd1:    nib = shape[11:8];
        2'd2:    nib = shape[7:4];
        default: nib = shape[3:0];
      endcase
      r = WIN'(nib) << cl;
    end
    return r;
  endfunction

  function automatic logic [WIN*TW-1:0] build_tpl(input logic [WIN-1:0] row,
                                                  input logic [TW-1:0] code);
    logic [WIN*TW-1:0] t;
    logic [WIN-1:0]    rr;
    t  = '0;
    rr = row;
    for (int i = 0; i < WIN; i++) begin
      t  = {t[WIN*TW-TW-1:0], (rr[WIN-1] ? code : C_BLACK)};
      rr = rr << 1;
    end
    return t;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        piece_q, piece_d;
  logic [2:0]        crop_l_q, crop_l_d;
  logic [2:0]        crop_t_q, crop_t_d;
  logic [1:0]        rot_q, rot_d;
  logic [15:0]       shape_q, shape_d;
  logic [TW-1:0]     tcode_q, tcode_d;
  logic [IW-1:0]     row_idx_q, row_idx_d;
  logic [WIN-1:0]    row_data_q, row_data_d;
  logic [WIN*TW-1:0] row_tpl_q, row_tpl_d;
  logic              bad_q, bad_d;
  logic [15:0]       lk_shape_s;
  logic [WIN-1:0]    next_row_s;

`ifdef TETROMINO_MIRROR_EN
  function automatic logic [3:0] rev4(input logic [3:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  logic mirror_q, mirror_d;

  always_comb begin
    mirror_d = (state_q == IDLE && req_valid) ? mirror : mirror_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mirror_q <= 1'b0;
    else          mirror_q <= mirror_d;
  end

  always_comb begin
    lk_shape_s = shape_rows(piece_q, rot_q);
    if (mirror_q) begin
      lk_shape_s = {rev4(lk_shape_s[15:12]), rev4(lk_shape_s[11:8]),
                    rev4(lk_shape_s[7:4]), rev4(lk_shape_s[3:0])};
    end else begin
      lk_shape_s = shape_rows(piece_q, rot_q);
    end
  end
`else
  logic unused_mirror_s;
  assign unused_mirror_s = mirror;

  always_comb begin
    lk_shape_s = shape_rows(piece_q, rot_q);
  end
`endif

  always_comb begin
    state_d    = state_q;
    piece_d    = piece_q;
    crop_l_d   = crop_l_q;
    crop_t_d   = crop_t_q;
    rot_d      = rot_q;
    shape_d    = shape_q;
    tcode_d    = tcode_q;
    row_idx_d  = row_idx_q;
    row_data_d = row_data_q;
    row_tpl_d  = row_tpl_q;
    bad_d      = 1'b0;
    next_row_s = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          piece_d  = piece_id;
          crop_l_d = crop_left;
          crop_t_d = crop_top;
          bad_d    = (piece_id == 3'd7);
          rot_d    = (piece_id == 3'd7) ? rot_q : next_rot(rot_q, rot_cmd, orient_mask(piece_id));
          state_d  = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        next_row_s = build_row(lk_shape_s, crop_l_q, crop_t_q, 0);
        shape_d    = lk_shape_s;
        tcode_d    = tcode_of(piece_q);
        row_idx_d  = '0;
        row_data_d = next_row_s;
        row_tpl_d  = build_tpl(next_row_s, tcode_of(piece_q));
        state_d    = STREAM;
      end
      STREAM: begin
        if (row_ready) begin
          if (row_idx_q == IW'(WIN - 1)) begin
            state_d    = IDLE;
            row_idx_d  = '0;
            row_data_d = '0;
            row_tpl_d  = {WIN{C_BLACK}};
          end else begin
            next_row_s = build_row(shape_q, crop_l_q, crop_t_q, int'(row_idx_q) + 1);
            row_idx_d  = row_idx_q + IW'(1);
            row_data_d = next_row_s;
            row_tpl_d  = build_tpl(next_row_s, tcode_q);
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      piece_q    <= 3'd0;
      crop_l_q   <= 3'd0;
      crop_t_q   <= 3'd0;
      rot_q      <= 2'd0;
      shape_q    <= 16'h0000;
      tcode_q    <= C_BLACK;
      row_idx_q  <= '0;
      row_data_q <= '0;
      row_tpl_q  <= {WIN{C_BLACK}};
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      piece_q    <= piece_d;
      crop_l_q   <= crop_l_d;
      crop_t_q   <= crop_t_d;
      rot_q      <= rot_d;
      shape_q    <= shape_d;
      tcode_q    <= tcode_d;
      row_idx_q  <= row_idx_d;
      row_data_q <= row_data_d;
      row_tpl_q  <= row_tpl_d;
      bad_q      <= bad_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign row_valid    = (state_q == STREAM);
  assign row_last     = (state_q == STREAM) && (row_idx_q == IW'(WIN - 1));
  assign row_data     = row_data_q;
  assign row_template = row_tpl_q;
  assign row_idx      = row_idx_q;
  assign rot_state    = rot_q;
  assign bad_piece    = bad_q;

endmodule

// File: tb/tb_tetromino_row_streamer.sv
// Scoreboard bench for tetromino_row_streamer at WIN=4, TW=2.
module tb_tetromino_row_streamer;
  import template_pkg::*;

  localparam int WIN = 4;
  localparam int TW  = 2;

  typedef struct packed {
    logic [3:0] d;
    logic [7:0] t;
    logic [1:0] idx;
    logic       last;
  } row_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] piece_id = 3'd0;
  logic [1:0] rot_cmd = 2'd0;
  logic [2:0] crop_left = 3'd0;
  logic [2:0] crop_top = 3'd0;
  logic       mirror = 1'b0;
  logic       row_valid;
  logic       row_ready = 1'b1;
  logic [3:0] row_data;
  logic [7:0] row_template;
  logic [1:0] row_idx;
  logic       row_last;
  logic [1:0] rot_state;
  logic       bad_piece;

  int   n_pass = 0;
  int   n_total = 0;
  row_t exp_q[$];

  tetromino_row_streamer #(.WIN(WIN), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .piece_id(piece_id), .rot_cmd(rot_cmd),
    .crop_left(crop_left), .crop_top(crop_top), .mirror(mirror),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_template(row_template),
    .row_idx(row_idx), .row_last(row_last),
    .rot_state(rot_state), .bad_piece(bad_piece)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tpl_of(input logic [3:0] d, input logic [1:0] code);
    logic [7:0] t;
    logic [3:0] dd;
    t  = 8'h00;
    dd = d;
    for (int i = 0; i < 4; i++) begin
      t  = {t[5:0], (dd[3] ? code : BLACK)};
      dd = dd << 1;
    end
    return t;
  endfunction

  task automatic push_stream(input logic [15:0] rows, input logic [1:0] code);
    row_t e;
    for (int k = 0; k < 4; k++) begin
      e.d    = 4'(rows >> (12 - 4 * k));
      e.t    = tpl_of(e.d, code);
      e.idx  = 2'(k);
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endtask

  // Drives one request at a negedge; returns at the negedge after the accepting edge (LOOKUP).
  task automatic send_req(input logic [2:0] p, input logic [1:0] rc, input logic [2:0] cl,
                          input logic [2:0] ct, input logic m);
    @(negedge clk);
    req_valid = 1'b1; piece_id = p; rot_cmd = rc; crop_left = cl; crop_top = ct; mirror = m;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect_row(output bit got, output row_t obs);
    got = 1'b0;
    obs = '0;
    for (int c = 0; c < 20; c++) begin
      if (row_valid === 1'b1) break;
      @(negedge clk);
    end
    if (row_valid === 1'b1) begin
      got = 1'b1;
      obs = {row_data, row_template, row_idx, row_last};
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({req_ready, row_valid, row_last, bad_piece} !== 4'b1000)
      $display("FAIL reset_flags: got %b want 1000", {req_ready, row_valid, row_last, bad_piece});
    else n_pass++;
    n_total++;
    if ({row_data, row_template, row_idx, rot_state} !== 16'h0000)
      $display("FAIL reset_values: got %h want 0000", {row_data, row_template, row_idx, rot_state});
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || row_valid !== 1'b0)
      $display("FAIL reset_release: got ready=%b valid=%b want 1/0", req_ready, row_valid);
    else n_pass++;
  endtask

  task automatic test_t_spawn();
    bit got; row_t obs, exp;
    push_stream(16'h0072, WHITE);
    send_req(3'd4, 2'b00, 3'd0, 3'd0, 1'b0);
    n_total++;
    if ({req_ready, row_valid, bad_piece, rot_state} !== 5'b00000)
      $display("FAIL t_spawn_lookup: got %b want 00000", {req_ready, row_valid, bad_piece, rot_state});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (row_valid !== 1'b1) $display("FAIL t_spawn_latency: got valid=%b want 1", row_valid);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL t_spawn_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
    n_total++;
    if (req_ready !== 1'b1 || row_valid !== 1'b0)
      $display("FAIL t_spawn_idle: got ready=%b valid=%b want 1/0", req_ready, row_valid);
    else n_pass++;
  endtask

  task automatic test_rotation();
    bit got, all_got; row_t obs, exp;
    logic [2:0] sp [10] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd1};
    logic [1:0] sc [10] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] sr [10] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    push_stream(16'h0262, WHITE);
    send_req(3'd4, 2'b01, 3'd0, 3'd0, 1'b0);
    n_total++;
    if (rot_state !== 2'd1) $display("FAIL rot_t_cw: got %0d want 1", rot_state);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL rot_t_cw_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
    for (int s = 0; s < 10; s++) begin
      send_req(sp[s], sc[s], 3'd0, 3'd0, 1'b0);
      n_total++;
      if (rot_state !== sr[s])
        $display("FAIL rot_seq%0d: piece %0d cmd %b got %0d want %0d", s, sp[s], sc[s], rot_state, sr[s]);
      else n_pass++;
      all_got = 1'b1;
      for (int k = 0; k < 4; k++) begin
        collect_row(got, obs);
        all_got &= got;
      end
      n_total++;
      if (!all_got) $display("FAIL rot_seq%0d_stream: got incomplete want 4 rows", s);
      else n_pass++;
    end
  endtask

  task automatic test_crop_stall();
    bit got; row_t obs, held, exp;
    logic [2:0] cl [3] = '{3'd4, 3'd0, 3'd0};
    logic [2:0] ct [3] = '{3'd0, 3'd4, 3'd2};
    logic [15:0] er [3] = '{16'h0000, 16'h0000, 16'h7200};
    push_stream(16'h0E40, WHITE);
    send_req(3'd4, 2'b00, 3'd1, 3'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 20; c++) begin
        if (row_valid === 1'b1) break;
        @(negedge clk);
      end
      obs = {row_data, row_template, row_idx, row_last};
      got = (row_valid === 1'b1);
      row_ready = 1'b0;
      @(negedge clk);
      held = {row_data, row_template, row_idx, row_last};
      n_total++;
      if (row_valid !== 1'b1 || held !== obs)
        $display("FAIL crop_stall_hold%0d: got %h valid=%b want %h valid=1", k, held, row_valid, obs);
      else n_pass++;
      row_ready = 1'b1;
      @(negedge clk);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL crop_stall_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
    for (int s = 0; s < 3; s++) begin
      push_stream(er[s], WHITE);
      send_req(3'd4, 2'b00, cl[s], ct[s], 1'b0);
      for (int k = 0; k < 4; k++) begin
        collect_row(got, obs);
        exp = exp_q.pop_front();
        n_total++;
        if (!got || obs !== exp)
          $display("FAIL crop%0d_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                   s, k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bad_piece();
    bit got; row_t obs, exp;
    send_req(3'd4, 2'b01, 3'd0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) collect_row(got, obs);
    push_stream(16'h0000, BLACK);
    send_req(3'd7, 2'b01, 3'd0, 3'd0, 1'b0);
    n_total++;
    if (bad_piece !== 1'b1 || rot_state !== 2'd1)
      $display("FAIL bad_lookup: got bad=%b rot=%0d want 1/1", bad_piece, rot_state);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bad_piece !== 1'b0) $display("FAIL bad_pulse_width: got %b want 0", bad_piece);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL bad_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit got; row_t obs, exp;
    push_stream(16'h0072, WHITE);
    send_req(3'd4, 2'b11, 3'd0, 3'd0, 1'b0);
    req_valid = 1'b1; piece_id = 3'd1; rot_cmd = 2'b01; crop_left = 3'd3;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_valid = 1'b0;
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL busy_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
    n_total++;
    if (rot_state !== 2'd0 || req_ready !== 1'b1)
      $display("FAIL busy_ignored: got rot=%0d ready=%b want 0/1", rot_state, req_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (row_valid !== 1'b0) $display("FAIL busy_no_queue: got valid=%b want 0", row_valid);
    else n_pass++;
  endtask

  task automatic test_mirror();
    bit got; row_t obs, exp;
`ifdef TETROMINO_MIRROR_EN
    push_stream(16'h00E8, DARK);
`else
    push_stream(16'h0071, DARK);
`endif
    send_req(3'd5, 2'b00, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL mirror_j_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stream();
    bit got; row_t obs, exp;
    send_req(3'd3, 2'b01, 3'd0, 3'd0, 1'b0);
    n_total++;
    if (rot_state !== 2'd1) $display("FAIL s_cw_rot: got %0d want 1", rot_state);
    else n_pass++;
    for (int k = 0; k < 2; k++) collect_row(got, obs);
    n_total++;
    if (row_valid !== 1'b1 || row_idx !== 2'd2)
      $display("FAIL s_row2_reached: got valid=%b idx=%0d want 1/2", row_valid, row_idx);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({row_valid, req_ready, rot_state, row_data} !== 8'b0100_0000)
      $display("FAIL async_abort: got %b want 01000000", {row_valid, req_ready, rot_state, row_data});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (row_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL abort_no_rows: got valid=%b ready=%b want 0/1", row_valid, req_ready);
    else n_pass++;
    push_stream(16'h0072, WHITE);
    send_req(3'd4, 2'b00, 3'd0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      collect_row(got, obs);
      exp = exp_q.pop_front();
      n_total++;
      if (!got || obs !== exp)
        $display("FAIL post_reset_row%0d: got %b/%h/%0d/%b (seen=%0b) want %b/%h/%0d/%b",
                 k, obs.d, obs.t, obs.idx, obs.last, got, exp.d, exp.t, exp.idx, exp.last);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_t_spawn();
    test_rotation();
    test_crop_stall();
    test_bad_piece();
    test_back_to_back();
    test_mirror();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
